// File: rtl/ast_result_drain_sv_if.sv
// Result stream interface between the drain and the output FIFO/memory writer.
// master (drain): drives out_data, out_row, out_col, out_last, out_valid.
// slave  (sink) : drives out_ready.
interface ast_result_drain_sv_if #(
  parameter int SIZE      = 4,
  parameter int DATAWIDTH = 14
);
  localparam int IW = $clog2(SIZE);

  logic [DATAWIDTH-1:0] out_data;
  logic [IW-1:0]        out_row;
  logic [IW-1:0]        out_col;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data, out_row, out_col, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_col, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/ast_result_drain_sv.sv
// Result drain for the systolic array accumulators.
// Captures the whole SIZE x SIZE result matrix in one cycle on start, so the
// array is free immediately, then streams the snapshot row-major over a
// valid/ready interface.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      capture request, honoured only while idle
//   d_in       result matrix from the array, d_in[row][col]
//   out        result stream (master side of ast_result_drain_sv_if)
//   busy       snapshot held / streaming in progress
//   done       one-cycle pulse after the final beat transfers
//   start_err  sticky: start seen while busy
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | no snapshot held, waiting for start
// STREAM | snapshot held, presenting snapshot[row][col]
module ast_result_drain_sv #(
  parameter int SIZE      = 4,
  parameter int DATAWIDTH = 14
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [SIZE-1:0][SIZE-1:0][DATAWIDTH-1:0]  d_in,
  ast_result_drain_sv_if.master                     out,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      start_err
);

  localparam int            IW   = $clog2(SIZE);
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0][SIZE-1:0][DATAWIDTH-1:0] snap_q;
  logic [IW-1:0] row_q, col_q;
  logic          done_q, start_err_q;
  logic          capture, xfer, xfer_last;

  assign capture   = (state_q == IDLE) && start;
  assign xfer      = out.out_valid && out.out_ready;
  assign xfer_last = xfer && out.out_last;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = STREAM;
      STREAM:  if (xfer_last) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // snapshot, element pointer and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      done_q <= xfer_last;
      if (start && (state_q == STREAM)) start_err_q <= 1'b1;
      if (capture) begin
        snap_q <= d_in;
        row_q  <= '0;
        col_q  <= '0;
      end else if (xfer) begin
        if (col_q == LAST) begin
          col_q <= '0;
          // explicit wrap keeps the pointer at [0][0] when SIZE is not a power of two
          row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // outputs (combinational from state so reset drops them immediately)
  always_comb begin
    out.out_valid = (state_q == STREAM);
    out.out_data  = snap_q[row_q][col_q];
    out.out_row   = row_q;
    out.out_col   = col_q;
    out.out_last  = (row_q == LAST) && (col_q == LAST) && (state_q == STREAM);
    busy          = (state_q == STREAM);
    done          = done_q;
    start_err     = start_err_q;
  end

endmodule

// File: tb/tb_ast_result_drain_sv.sv
module tb_ast_result_drain_sv;
  localparam int SIZE = 4;
  localparam int DW   = 14;

  logic clk;
  logic reset;
  logic start;
  logic [SIZE-1:0][SIZE-1:0][DW-1:0] d_in;
  logic busy, done, start_err;

  ast_result_drain_sv_if #(.SIZE(SIZE), .DATAWIDTH(DW)) bus ();

  ast_result_drain_sv #(.SIZE(SIZE), .DATAWIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .d_in      (d_in),
    .out       (bus),
    .busy      (busy),
    .done      (done),
    .start_err (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  // expected beat: {last, row, col, data}
  logic [DW+4:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        d_in[r][c] = DW'(16 * r + c);
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        d_in[r][c] = v;
  endtask

  // Issue a one-cycle start (called just after a rising edge) and queue the
  // hand-derived tile; checks first-beat latency.
  task automatic start_tile();
    logic [DW-1:0] first;
    first = d_in[0][0];
    start = 1'b1;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        expq.push_back({(r == SIZE-1 && c == SIZE-1), 2'(r), 2'(c), d_in[r][c]});
    tick(1);
    start = 1'b0;
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_data", 32'(bus.out_data), 32'(first));
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (expq.size() == 0) break;
      tick(1);
    end
    chk("drain_timeout", 32'(expq.size()), 32'd0);
  endtask

  // monitor / scoreboard
  logic          expect_done = 1'b0;
  logic          prev_stall  = 1'b0;
  logic [DW+4:0] prev_beat;

  always @(negedge clk) begin
    logic [DW+4:0] act, exp;
    if (!reset) begin
      expect_done = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      act = {bus.out_last, bus.out_row, bus.out_col, bus.out_data};
      if (expect_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
      end else if (done) begin
        chk("spurious_done", 32'(done), 32'd0);
      end
      expect_done = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_beat", 32'(act), 32'(prev_beat));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 32'(act), 32'h7fffffff);
        end else begin
          exp = expq.pop_front();
          chk("beat", 32'(act), 32'(exp));
          if (bus.out_last) expect_done = 1'b1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_beat  = act;
    end
  end

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;  // ready pattern 1,0,0,1 (bit i used in cycle i)
    reset = 1'b0;
    start = 1'b0;
    bus.out_ready = 1'b0;
    fill_ramp();
    tick(3);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(start_err), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_row", 32'(bus.out_row), 32'd0);
    chk("rst_col", 32'(bus.out_col), 32'd0);
    reset = 1'b1;
    tick(2);

    // 1: full-throughput tile
    bus.out_ready = 1'b1;
    start_tile();
    tick(16);
    chk("t1_drained", 32'(expq.size()), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    tick(1);
    chk("t1_done_once", 32'(done), 32'd0);
    chk("t1_err", 32'(start_err), 32'd0);
    tick(2);

    // 2: backpressure pattern
    start_tile();
    for (int i = 0; i < 200; i++) begin
      if (expq.size() == 0) break;
      bus.out_ready = pat[i % 4];
      tick(1);
    end
    chk("t2_drained", 32'(expq.size()), 32'd0);
    bus.out_ready = 1'b1;
    tick(3);

    // 3: d_in changes after capture
    start_tile();
    fill_const(14'h3FFF);
    wait_empty(40);
    tick(3);
    fill_ramp();

    // 4: start while busy, including the last-transfer edge
    start_tile();
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t4_err", 32'(start_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    tick(5);
    chk("t4_no_tile", 32'(bus.out_valid), 32'd0);
    chk("t4_err_hold", 32'(start_err), 32'd1);
    chk("t4_q", 32'(expq.size()), 32'd0);

    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);

    // 5: start in the done cycle
    start_tile();
    tick(16);
    chk("t5_in_done", 32'(done), 32'd1);
    fill_const(14'h2AAA);
    start_tile();
    wait_empty(40);
    tick(2);
    chk("t5_err", 32'(start_err), 32'd0);
    fill_ramp();

    // 6: asynchronous reset mid-stream
    start_tile();
    tick(7);
    #2;
    expq.delete();
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_last", 32'(bus.out_last), 32'd0);
    chk("t6_data", 32'(bus.out_data), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("t6_idle", 32'(bus.out_valid), 32'd0);
    start_tile();
    wait_empty(40);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
